// File: rtl/mux_pkg.sv
// Shared types for the arbitrated N-channel selector.
package mux_pkg;

  typedef enum logic {MODO_FIXO = 1'b0, MODO_RR = 1'b1} modo_t;
  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

  // Next channel index modulo n; n need not be a power of two.
  function automatic int prox_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_arbitrado_rr_arbitro.sv
// Combinational round-robin search: starts after ponteiro, ponteiro itself is tried last.
module arbitro_rr
  import mux_pkg::*;
#(
  parameter  int N_CANAIS = 8,
  localparam int SEL_W    = $clog2(N_CANAIS)
) (
  input  logic [N_CANAIS-1:0] req,
  input  logic [SEL_W-1:0]    ponteiro,
  input  logic                habilita,
  output logic                grant_valido,
  output logic [SEL_W-1:0]    grant_idx
);

  always_comb begin
    int idx;
    grant_valido = 1'b0;
    grant_idx    = '0;
    idx          = int'(ponteiro);
    for (int k = 0; k < N_CANAIS; k++) begin
      idx = prox_idx(idx, N_CANAIS);
      if (habilita && !grant_valido && req[idx]) begin
        grant_valido = 1'b1;
        grant_idx    = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arbitrado_rr.sv
// N-channel W-bit selector with valid/ready handshake, fixed or round-robin grant,
// and a single registered output stage.
module mux_arbitrado_rr
  import mux_pkg::*;
#(
  parameter  int N_CANAIS = 8,
  parameter  int LARGURA  = 8,
  localparam int SEL_W    = $clog2(N_CANAIS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  modo_t                             modo,
  input  logic [SEL_W-1:0]                  seletor,
  input  logic [N_CANAIS-1:0][LARGURA-1:0]  entrada_dados,
  input  logic [N_CANAIS-1:0]               entrada_valida,
  output logic [N_CANAIS-1:0]               entrada_pronta,
  output logic [LARGURA-1:0]                saida_dados,
  output logic                              saida_valida,
  input  logic                              saida_pronta,
  output logic [SEL_W-1:0]                  saida_canal
);

  estado_t          estado, estado_prox;
  logic [SEL_W-1:0] ponteiro;
  logic             carrega;
  logic             fixo_valido;
  logic             rr_valido;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valido;
  logic [SEL_W-1:0] grant_idx;

  // Output register can take a word when empty or when it is being drained.
  assign carrega = (estado == VAZIO) || saida_pronta;

  // Decoding against every legal index keeps out-of-range seletor values grant-free.
  always_comb begin
    fixo_valido = 1'b0;
    for (int i = 0; i < N_CANAIS; i++)
      if (seletor == SEL_W'(i) && entrada_valida[i]) fixo_valido = carrega;
  end

  arbitro_rr #(.N_CANAIS(N_CANAIS)) u_arbitro (
    .req          (entrada_valida),
    .ponteiro     (ponteiro),
    .habilita     (carrega && (modo == MODO_RR)),
    .grant_valido (rr_valido),
    .grant_idx    (rr_idx)
  );

  always_comb begin
    grant_valido = 1'b0;
    grant_idx    = '0;
    if (modo == MODO_RR) begin
      grant_valido = rr_valido;
      grant_idx    = rr_idx;
    end else begin
      grant_valido = fixo_valido;
      grant_idx    = seletor;
    end
  end

  // Ready is masked during reset so producers never see a handshake that will not land.
  always_comb begin
    entrada_pronta = '0;
    for (int i = 0; i < N_CANAIS; i++)
      entrada_pronta[i] = rst_n && grant_valido && (grant_idx == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= VAZIO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox  = estado;
    saida_valida = (estado == CHEIO);
    case (estado)
      VAZIO:   if (grant_valido) estado_prox = CHEIO;
      CHEIO:   if (saida_pronta && !grant_valido) estado_prox = VAZIO;
      default: estado_prox = VAZIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_dados <= '0;
      saida_canal <= '0;
      ponteiro    <= SEL_W'(N_CANAIS - 1);
    end else if (grant_valido) begin
      saida_dados <= entrada_dados[grant_idx];
      saida_canal <= grant_idx;
      ponteiro    <= grant_idx;
    end
  end

endmodule

// File: tb/tb_mux_arbitrado_rr.sv
// Randomized bench for mux_arbitrado_rr at (8 ch, 8 bit) and (5 ch, 16 bit), with a
// behavioural model, a per-channel sequence scoreboard and directed literal checks.
module tb_mux_arbitrado_rr;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N  = (g == 0) ? 8 : 5;
    localparam int W  = (g == 0) ? 8 : 16;
    localparam int SW = $clog2(N);

    logic                 rst_n;
    modo_t                modo;
    logic [SW-1:0]        sel;
    logic [N-1:0][W-1:0]  dat;
    logic [N-1:0]         vld;
    logic                 pronta;
    logic [N-1:0]         epr;
    logic [W-1:0]         sd;
    logic                 sv;
    logic [SW-1:0]        sc;

    // model state: contents of the output register after the last edge
    logic                 m_v;
    logic [W-1:0]         m_d;
    int                   m_c, m_p;
    logic [N-1:0]         acc;
    int                   cons_seq [N];
    int                   prod_seq [N];
    int                   in_cnt  = 0;
    int                   out_cnt = 0;
    bit                   sb_on   = 1'b0;
    bit                   fim     = 1'b0;

    mux_arbitrado_rr #(.N_CANAIS(N), .LARGURA(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .modo           (modo),
      .seletor        (sel),
      .entrada_dados  (dat),
      .entrada_valida (vld),
      .entrada_pronta (epr),
      .saida_dados    (sd),
      .saida_valida   (sv),
      .saida_pronta   (pronta),
      .saida_canal    (sc)
    );

    task automatic c(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("N%0d %s", N, nm), act, exp);
    endtask

    function automatic logic [W-1:0] enc(input int ch, input int s);
      return W'((ch << (W - 3)) | (s & ((1 << (W - 3)) - 1)));
    endfunction

    // Which channel wins: -1 if none.
    function automatic int grant_of(input modo_t md, input int s, input logic [N-1:0] v, input int p);
      if (md == MODO_FIXO) begin
        if (s < N) return v[s] ? s : -1;
        return -1;
      end
      for (int k = 1; k <= N; k++)
        if (v[(p + k) % N]) return (p + k) % N;
      return -1;
    endfunction

    // Inputs change only just after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
      int gi;
      bit ld;
      logic [63:0] ep;
      acc = vld & epr;
      if (!rst_n) begin
        c("reset_valida", sv, 0);
        c("reset_dados", sd, 0);
        c("reset_canal", sc, 0);
        c("reset_pronta", epr, 0);
        m_v = 1'b0; m_d = '0; m_c = 0; m_p = N - 1;
      end else begin
        c("saida_valida", sv, m_v);
        c("saida_dados", sd, m_d);
        c("saida_canal", sc, m_c);
        ld = !m_v || pronta;
        gi = ld ? grant_of(modo, int'(sel), vld, m_p) : -1;
        ep = (gi >= 0) ? (64'd1 << gi) : 64'd0;
        c("entrada_pronta", epr, ep);
        if (sb_on) begin
          for (int i = 0; i < N; i++) if (acc[i]) in_cnt++;
          if (sv && pronta) begin
            c("sb_palavra", sd, enc(int'(sc), cons_seq[sc]));
            cons_seq[sc]++;
            out_cnt++;
          end
        end
        if (gi >= 0) begin
          m_v = 1'b1; m_d = dat[gi]; m_c = gi; m_p = gi;
        end else if (ld) begin
          m_v = 1'b0;
        end
      end
    end

    task automatic paso();
      @(posedge clk);
      #1;
    endtask

    initial begin
      for (int i = 0; i < N; i++) begin
        dat[i] = W'(16 + i);
        prod_seq[i] = 0;
        cons_seq[i] = 0;
      end
      rst_n = 1'b0; modo = MODO_FIXO; sel = SW'(3); vld = '1; pronta = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      c("hold_valida", sv, 0);
      c("hold_pronta", epr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      c("fixo_pronta0", epr, 8);
      for (int k = 0; k < 4; k++) begin
        paso(); @(negedge clk);
        c("fixo_dados", sd, 'h13);
        c("fixo_canal", sc, 3);
        c("fixo_pronta", epr, 8);
      end
      // asynchronous reset in the middle of a cycle
      paso(); #2; rst_n = 1'b0; #1;
      c("async_valida", sv, 0);
      c("async_dados", sd, 0);
      c("async_canal", sc, 0);
      c("async_pronta", epr, 0);
      modo = MODO_RR;
      paso(); rst_n = 1'b1;
      for (int k = 0; k <= N; k++) begin
        paso();
        if (k == N) begin vld = '0; vld[2] = 1'b1; vld[N-2] = 1'b1; end
        @(negedge clk);
        c("rr_canal", sc, k % N);
        c("rr_valida", sv, 1);
      end
      for (int j = 0; j < 4; j++) begin
        paso();
        if (j == 3) begin vld = '0; vld[2] = 1'b1; end
        @(negedge clk);
        c("rr_par", sc, (j % 2 == 0) ? 2 : N - 2);
      end
      for (int j = 0; j < 3; j++) begin
        paso();
        if (j == 2) vld = '1;
        @(negedge clk);
        c("rr_so2", sc, 2);
      end
      // backpressure
      paso(); pronta = 1'b0; @(negedge clk);
      c("bp_canal0", sc, 3);
      for (int k = 0; k < 4; k++) begin
        paso();
        if (k == 3) pronta = 1'b1;
        @(negedge clk);
        c("bp_canal", sc, 3);
        c("bp_dados", sd, 'h13);
        c("bp_valida", sv, 1);
        c("bp_pronta", epr, (k == 3) ? 64'd16 : 64'd0);
      end
      paso(); modo = MODO_FIXO; sel = SW'(7); @(negedge clk);
      c("bp_libera", sc, 4);
      c("bp_libera_dados", sd, 'h14);
      repeat (3) paso();
      @(negedge clk);
      c("sel7_valida", sv, (7 < N) ? 1 : 0);
      c("sel7_pronta", epr, (7 < N) ? (64'd1 << 7) : 64'd0);
      // empty the output, then random traffic with sequence-numbered words
      paso(); vld = '0;
      repeat (2) paso();
      sb_on = 1'b1;
      for (int cy = 0; cy < 400; cy++) begin
        paso();
        for (int i = 0; i < N; i++)
          if (acc[i]) begin prod_seq[i]++; vld[i] = 1'b0; end
        for (int i = 0; i < N; i++)
          if (!vld[i] && $urandom_range(0, 2) != 0) begin
            vld[i] = 1'b1;
            dat[i] = enc(i, prod_seq[i]);
          end
        pronta = ($urandom_range(0, 3) != 0);
        if (cy == 40) modo = MODO_RR;
        if (cy > 100 && $urandom_range(0, 15) == 0) begin
          modo = modo_t'($urandom_range(0, 1));
          sel  = SW'($urandom_range(0, (1 << SW) - 1));
        end
      end
      for (int cy = 0; cy < N + 6; cy++) begin
        paso();
        for (int i = 0; i < N; i++)
          if (acc[i]) begin prod_seq[i]++; vld[i] = 1'b0; end
        modo = MODO_RR; pronta = 1'b1;
      end
      @(negedge clk);
      c("sb_contagem", out_cnt, in_cnt);
      c("sb_atividade", (in_cnt > 50) ? 1 : 0, 1);
      c("sb_vazio", {vld != '0, sv}, 0);
      sb_on = 1'b0;
      fim   = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (cfg[0].fim && cfg[1].fim) break;
      @(posedge clk);
    end
    chk("fim_dos_testes", {62'd0, cfg[1].fim, cfg[0].fim}, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
